mem_arbiter: RTL and testbench

Two-client arbiter and sequencer for the shared single-port 16x8 Memory block (en, r_w, 4-bit addr, bidirectional 8-bit data). It grants one client access per transaction, drives the memory control lines from registers, owns the tri-state drive of the shared data bus, and returns read data with a valid strobe. It sits between the Memory instance and two independent producers/consumers, such as a LIFO loader and an output drainer.

---
 rtl/mem_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
//------------------------------------------------------------------------------
// mem_arbiter
//
// Two-client arbiter and sequencer for a shared single-port 16x8 memory.
// It grants one client per transaction and drives the memory control lines
// from registers. It owns the tri-state drive of the shared data bus and
// returns read data with a one-cycle valid strobe.
//
// Transaction shapes (edge k = request sampled in IDLE):
//   write : GRANT in cycle k..k+1, memory writes at edge k+1   (2 cycles)
//   read  : GRANT in cycle k..k+1, memory drives bus k+1..k+2,
//           rdata/rvalid valid in cycle k+2..k+3              (3 cycles)
//
// Ports
//   clk, reset          system clock; synchronous active-high reset
//   req0/1, we0/1       client request (held until gnt), 1 = write
//   addr0/1, wdata0/1   client address and write data
//   gnt0/1              one-cycle pulse: request accepted
//   rvalid0/1           one-cycle pulse: rdata holds the read result
//   rdata               shared read data register
//   busy                high whenever the sequencer is not idle
//   mem_en, mem_r_w     memory enable, 1 = read / 0 = write
//   mem_addr            memory address (passed through unmodified)
//   mem_data            shared bidirectional bus, driven only in a write GRANT
//
// Build option
//   MEM_ARB_FIXED_PRI_EN : client 0 always wins a tie and no last-grant
//                          pointer is built (client 1 may starve).
//                          Undefined: round-robin on a last-grant pointer.
//------------------------------------------------------------------------------
module mem_arbiter #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req0,
   input  logic              req1,
   input  logic              we0,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata0,
   input  logic [DATA_W-1:0] wdata1,
   output logic              gnt0,
   output logic              gnt1,
   output logic              rvalid0,
   output logic              rvalid1,
   output logic [DATA_W-1:0] rdata,
   output logic              busy,
   output logic              mem_en,
   output logic              mem_r_w,
   output logic [ADDR_W-1:0] mem_addr,
   inout  wire  [DATA_W-1:0] mem_data
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      RDATA = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic                client_q, client_d;   // client owning the current transaction
   logic                drive_q, drive_d;     // mem_data output enable
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic                gnt0_d, gnt1_d;
   logic                rvalid0_d, rvalid1_d;
   logic [DATA_W-1:0]   rdata_d;
   logic                mem_en_d, mem_r_w_d;
   logic [ADDR_W-1:0]   mem_addr_d;
   logic                win;                  // arbitration winner: 0 or 1

   //---------------------------------------------------------------------------
   // Arbitration
   //---------------------------------------------------------------------------
`ifdef MEM_ARB_FIXED_PRI_EN
   // Client 0 wins whenever it requests.
   assign win = ~req0;
`else
   logic last_q, last_d;                      // client granted last

   // A lone requester wins; on a tie the client not granted last wins.
   assign win = (req0 & req1) ? ~last_q : req1;

   always_comb begin
      last_d = last_q;
      if (state_q == IDLE && (req0 | req1))
         last_d = win;
   end

   always_ff @(posedge clk) begin
      if (reset) last_q <= 1'b1;              // client 0 wins the first tie
      else       last_q <= last_d;
   end
`endif

   //---------------------------------------------------------------------------
   // Next-state and next-output logic
   //---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every signal assigned here gets a default first so no path
      // through the case can leave one unassigned and infer a latch.
      state_d    = state_q;
      client_d   = client_q;
      drive_d    = 1'b0;
      wdata_d    = wdata_q;
      gnt0_d     = 1'b0;
      gnt1_d     = 1'b0;
      rvalid0_d  = 1'b0;
      rvalid1_d  = 1'b0;
      rdata_d    = rdata;
      mem_en_d   = 1'b0;
      mem_r_w_d  = mem_r_w;
      mem_addr_d = mem_addr;

      case (state_q)
         IDLE: begin
            if (req0 | req1) begin
               client_d   = win;
               gnt0_d     = ~win;
               gnt1_d     = win;
               mem_en_d   = 1'b1;
               mem_r_w_d  = win ? ~we1 : ~we0;
               mem_addr_d = win ? addr1 : addr0;
               wdata_d    = win ? wdata1 : wdata0;
               drive_d    = win ? we1 : we0;
               state_d    = GRANT;
            end
         end
         GRANT: begin
            // The memory performs the access at the edge closing this cycle.
            state_d = mem_r_w ? RDATA : IDLE;
         end
         RDATA: begin
            rdata_d   = mem_data;
            rvalid0_d = ~client_q;
            rvalid1_d = client_q;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   //---------------------------------------------------------------------------
   // Registers
   //---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      if (reset) begin
         state_q  <= IDLE;
         client_q <= 1'b0;
         drive_q  <= 1'b0;
         wdata_q  <= '0;
         gnt0     <= 1'b0;
         gnt1     <= 1'b0;
         rvalid0  <= 1'b0;
         rvalid1  <= 1'b0;
         rdata    <= '0;
         mem_en   <= 1'b0;
         mem_r_w  <= 1'b1;
         mem_addr <= '0;
      end else begin
         state_q  <= state_d;
         client_q <= client_d;
         drive_q  <= drive_d;
         wdata_q  <= wdata_d;
         gnt0     <= gnt0_d;
         gnt1     <= gnt1_d;
         rvalid0  <= rvalid0_d;
         rvalid1  <= rvalid1_d;
         rdata    <= rdata_d;
         mem_en   <= mem_en_d;
         mem_r_w  <= mem_r_w_d;
         mem_addr <= mem_addr_d;
      end
   end

   assign busy = (state_q != IDLE);

   // The bus is driven only during a write GRANT; the RDATA cycle and the
   // IDLE cycle after it leave it released, giving a turnaround after reads.
   assign mem_data = drive_q ? wdata_q : {DATA_W{1'bz}};

endmodule

// File: tb/tb_mem_arbiter.sv
//------------------------------------------------------------------------------
// tb_mem_arbiter
//
// Self-checking bench for mem_arbiter. A behavioural 16x8 memory sits on the
// shared bus. A transaction-level reference model predicts, for every cycle,
// the grant, bus control, busy, rvalid and rdata outputs from the most recent
// accepted transaction. Directed scenarios are followed by randomized client
// traffic with occasional resets.
//------------------------------------------------------------------------------
module tb_mem_arbiter;

   logic       clk = 1'b0;
   logic       reset;
   logic [1:0] c_req, c_we;
   logic [3:0] c_addr  [2];
   logic [7:0] c_wdata [2];

   logic       req0, req1, we0, we1;
   logic [3:0] addr0, addr1, mem_addr;
   logic [7:0] wdata0, wdata1, rdata;
   logic       gnt0, gnt1, rvalid0, rvalid1, busy, mem_en, mem_r_w;
   wire  [7:0] mem_data;

   assign req0 = c_req[0];  assign we0 = c_we[0];
   assign req1 = c_req[1];  assign we1 = c_we[1];
   assign addr0 = c_addr[0];  assign wdata0 = c_wdata[0];
   assign addr1 = c_addr[1];  assign wdata1 = c_wdata[1];

   mem_arbiter #(.ADDR_W(4), .DATA_W(8)) dut (
      .clk(clk), .reset(reset),
      .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
      .rdata(rdata), .busy(busy), .mem_en(mem_en), .mem_r_w(mem_r_w),
      .mem_addr(mem_addr), .mem_data(mem_data)
   );

   always #5 clk = ~clk;

   // Behavioural memory: writes at the edge ending an enabled write cycle,
   // drives read data during the cycle after an enabled read edge.
   logic [7:0] mem_arr [16];
   logic       mem_drv = 1'b0;
   logic [7:0] mem_q = 8'h00;
   always @(posedge clk) begin
      if (mem_en && !mem_r_w) mem_arr[mem_addr] <= mem_data;
      if (mem_en && mem_r_w)  mem_q <= mem_arr[mem_addr];
      mem_drv <= mem_en && mem_r_w;
   end
   assign mem_data = mem_drv ? mem_q : 8'hzz;

   //---------------------------------------------------------------------------
   // Checking
   //---------------------------------------------------------------------------
   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
   endtask

   //---------------------------------------------------------------------------
   // Reference model (transaction level)
   //---------------------------------------------------------------------------
   int         cyc = 0;          // edges seen so far
   int         next_sample = 0;  // first edge at which a new request can be accepted
   int         g_cyc = -100;     // edge of the most recent accepted transaction
   int         g_client = 0;
   bit         g_we = 1'b1;
   logic [3:0] g_addr;
   logic [7:0] g_wdata, g_rval;
   logic [7:0] exp_rdata = 8'h00;
   logic [7:0] ref_mem [16];
   bit         last = 1'b1;      // client granted last
   bit         rst_edge;
   int         mgrant;           // client accepted at this edge, -1 if none

   task automatic model_edge();
      int w;
      mgrant   = -1;
      rst_edge = reset;
      if (reset) begin
         g_cyc       = -100;
         g_we        = 1'b1;
         last        = 1'b1;
         next_sample = cyc + 1;
         exp_rdata   = 8'h00;
      end else begin
         if (!g_we && cyc == g_cyc + 2) exp_rdata = g_rval;
         if (cyc >= next_sample && (c_req[0] || c_req[1])) begin
`ifdef MEM_ARB_FIXED_PRI_EN
            w = c_req[0] ? 0 : 1;
`else
            if (c_req[0] && c_req[1]) w = last ? 0 : 1;
            else                      w = c_req[0] ? 0 : 1;
`endif
            mgrant   = w;
            last     = w[0];
            g_cyc    = cyc;
            g_client = w;
            g_we     = c_we[w];
            g_addr   = c_addr[w];
            g_wdata  = c_wdata[w];
            if (g_we) begin
               ref_mem[g_addr] = g_wdata;
               next_sample = cyc + 2;
            end else begin
               g_rval = ref_mem[g_addr];
               next_sample = cyc + 3;
            end
         end
      end
   endtask

   task automatic check_outputs();
      bit rd = !g_we;
      check("gnt0",    gnt0,    cyc == g_cyc && g_client == 0);
      check("gnt1",    gnt1,    cyc == g_cyc && g_client == 1);
      check("mem_en",  mem_en,  cyc == g_cyc);
      check("busy",    busy,    cyc == g_cyc || (rd && cyc == g_cyc + 1));
      check("rvalid0", rvalid0, rd && cyc == g_cyc + 2 && g_client == 0);
      check("rvalid1", rvalid1, rd && cyc == g_cyc + 2 && g_client == 1);
      check("rdata",   rdata,   exp_rdata);
      if (cyc == g_cyc) begin
         check("mem_r_w",  mem_r_w,  !g_we);
         check("mem_addr", mem_addr, g_addr);
         if (g_we) check("mem_data", mem_data, g_wdata);
      end
      if (rst_edge) begin
         check("rst_mem_r_w",  mem_r_w,  1);
         check("rst_mem_addr", mem_addr, 0);
      end
   endtask

   // One clock: inputs already set are sampled at the edge; outputs are
   // checked 1 time unit later.
   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
      model_edge();
      check_outputs();
   endtask

   // Single-client transaction: hold the request until gnt, then let it run
   // out. Reports the rdata seen with the client's rvalid and the pulse count.
   task automatic do_txn(input int c, input bit we, input logic [3:0] a,
                         input logic [7:0] d, output logic [7:0] rd_seen,
                         output int rv_cnt);
      bit done = 1'b0;
      c_req[c] = 1'b1; c_we[c] = we; c_addr[c] = a; c_wdata[c] = d;
      rd_seen = 8'h00; rv_cnt = 0;
      for (int i = 0; i < 12 && !done; i++) begin
         step();
         if ((c == 0) ? gnt0 : gnt1) done = 1'b1;
      end
      check("txn_grant_seen", done, 1);
      c_req[c] = 1'b0;
      repeat (3) begin
         step();
         if ((c == 0) ? rvalid0 : rvalid1) begin
            rv_cnt++;
            rd_seen = rdata;
         end
      end
   endtask

   //---------------------------------------------------------------------------
   // Stimulus
   //---------------------------------------------------------------------------
   initial begin
      logic [7:0] rd;
      int         cnt, n, first;
      int         order [4];
      int         gcyc  [4];
      int         rv0_cyc, g0_cyc, g1_cyc;

      for (int i = 0; i < 16; i++) begin
         mem_arr[i] = 8'h00;
         ref_mem[i] = 8'h00;
      end
      reset = 1'b1;
      c_req = 2'b00; c_we = 2'b00;
      c_addr[0] = 4'h0; c_addr[1] = 4'h0; c_wdata[0] = 8'h00; c_wdata[1] = 8'h00;
      repeat (3) step();
      reset = 1'b0;

      // Client 0 writes 0xA5 to address 3, then client 1 reads it back.
      do_txn(0, 1'b1, 4'd3, 8'hA5, rd, cnt);
      check("wr_no_rvalid", cnt, 0);
      do_txn(1, 1'b0, 4'd3, 8'h00, rd, cnt);
      check("rd_a5_data", rd, 8'hA5);
      check("rd_a5_rvalid_cnt", cnt, 1);

      // Both clients hold write requests for four grants.
      for (int k = 0; k < 4; k++) begin order[k] = 9; gcyc[k] = 0; end
      c_req = 2'b11; c_we = 2'b11;
      c_addr[0] = 4'd4; c_addr[1] = 4'd5; c_wdata[0] = 8'h40; c_wdata[1] = 8'h50;
      n = 0;
      for (int i = 0; i < 20 && n < 4; i++) begin
         step();
         if (gnt0 || gnt1) begin
            order[n] = gnt0 ? 0 : 1;
            gcyc[n]  = cyc;
            n++;
            if (gnt0) begin c_addr[0] = 4'd6; c_wdata[0] = 8'h60 + 8'(n); end
            else      begin c_addr[1] = 4'd7; c_wdata[1] = 8'h70 + 8'(n); end
         end
      end
      c_req = 2'b00;
      repeat (3) step();
      check("tie_grants", n, 4);
      for (int k = 0; k < 4; k++) begin
`ifdef MEM_ARB_FIXED_PRI_EN
         check("tie_order", order[k], 0);
`else
         check("tie_order", order[k], k % 2);
`endif
         if (k > 0) check("tie_gap", gcyc[k] - gcyc[k-1], 2);
      end

      // Client 0 read and client 1 write raised together: read served first.
      c_req = 2'b11; c_we = 2'b10;
      c_addr[0] = 4'd3; c_addr[1] = 4'd8; c_wdata[1] = 8'h88;
      rv0_cyc = -1; g0_cyc = -1; g1_cyc = -1; rd = 8'h00;
      for (int i = 0; i < 20 && (rv0_cyc < 0 || g1_cyc < 0); i++) begin
         step();
         if (gnt0)    begin g0_cyc = cyc; c_req[0] = 1'b0; end
         if (gnt1)    begin g1_cyc = cyc; c_req[1] = 1'b0; end
         if (rvalid0) begin rv0_cyc = cyc; rd = rdata; end
      end
      c_req = 2'b00;
      repeat (2) step();
      check("rw_read_first", g0_cyc >= 0 && g0_cyc < g1_cyc, 1);
      check("rw_rvalid0_data", rd, 8'hA5);
      check("rw_gnt1_after_rvalid0", g1_cyc - rv0_cyc, 1);

      // Reset during RDATA of a client 0 read.
      c_req = 2'b01; c_we = 2'b00; c_addr[0] = 4'd3;
      g0_cyc = -1;
      for (int i = 0; i < 10 && g0_cyc < 0; i++) begin
         step();
         if (gnt0) g0_cyc = cyc;
      end
      check("rst_read_granted", g0_cyc >= 0, 1);
      c_req = 2'b00;
      step();                      // RDATA cycle
      reset = 1'b1;
      step();
      check("rst_rvalid0", rvalid0, 0);
      check("rst_busy", busy, 0);
      reset = 1'b0;
      c_req = 2'b11; c_we = 2'b11;
      c_addr[0] = 4'd9; c_addr[1] = 4'd10; c_wdata[0] = 8'h99; c_wdata[1] = 8'hAA;
      first = -1;
      for (int i = 0; i < 10 && first < 0; i++) begin
         step();
         if (gnt0 || gnt1) first = gnt0 ? 0 : 1;
      end
      c_req = 2'b00;
      repeat (3) step();
      check("rst_tie_winner", first, 0);

      // Fill all 16 entries, then read them back in reverse order.
      for (int i = 0; i < 16; i++) do_txn(0, 1'b1, 4'(i), 8'h10 + 8'(i), rd, cnt);
      for (int i = 15; i >= 0; i--) begin
         do_txn(1, 1'b0, 4'(i), 8'h00, rd, cnt);
         check("seq_rdata", rd, 8'h10 + 8'(i));
         check("seq_rvalid_cnt", cnt, 1);
      end

      // Randomized traffic with occasional resets and dropped requests.
      for (int t = 0; t < 1500; t++) begin
         reset = ($urandom_range(199) == 0);
         step();
         for (int x = 0; x < 2; x++) begin
            if (mgrant == x) c_req[x] = 1'b0;
            if (!c_req[x]) begin
               if ($urandom_range(2) == 0) begin
                  c_req[x]   = 1'b1;
                  c_we[x]    = $urandom_range(1) == 1;
                  c_addr[x]  = 4'($urandom_range(15));
                  c_wdata[x] = 8'($urandom_range(255));
               end
            end else if (mgrant != x && $urandom_range(15) == 0) begin
               c_req[x] = 1'b0;
            end
         end
      end
      reset = 1'b0;
      c_req = 2'b00;
      repeat (4) step();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
